fifo_rd_packer: RTL
===================

# fifo_rd_packer

Read-side consumer of the asynchronous FIFO, running in the FIFO's read-clock domain. It pops WIDTH-bit words from the FIFO and packs LANES of them into one wide word. The wide word is presented downstream on a valid/ready handshake with a per-lane keep mask. Partial words are emitted on an explicit flush or after a programmable idle timeout.

## Interface
- WIDTH, 8, FIFO word width (bits)
- LANES, 4, FIFO words per output word (≥2)
- IDLE_MAX, 16, consecutive idle cycles before a partial word is emitted; 0 disables the timeout
- i_clk  in  1  clock; connect to the FIFO read clock
- i_rst  in  1  reset, asynchronous, active-high
- i_fifo_empty  in  1  FIFO empty flag
- i_fifo_data  in  WIDTH  FIFO head word, first-word-fall-through: valid whenever i_fifo_empty=0
- o_fifo_rinc  out  1  FIFO pop strobe
- o_data  out  WIDTH*LANES  packed word; lane 0 = bits [WIDTH-1:0] = oldest word
- o_keep  out  LANES  lane-valid mask
- o_valid  out  1  output word valid
- i_ready  in  1  downstream accepts
- i_flush  in  1  emit the current partial word

## Operation
- States: FILL, HOLD. Internal lane counter cnt (0..LANES-1). Internal idle counter idle (0..IDLE_MAX).
- o_fifo_rinc = (state==FILL) & ~i_fifo_empty & ~i_rst. This is the only combinational output.
- FILL, pop cycle:
  - i_fifo_data is written to lane cnt and keep[cnt] is set.
  - If cnt==LANES-1: go to HOLD with o_keep all ones and cnt reset to 0. Otherwise cnt increments.
  - idle is cleared.
- FILL, no pop, cnt>0: idle increments. When idle reaches IDLE_MAX (and IDLE_MAX≠0), go to HOLD with a partial o_keep.
- FILL, no pop, cnt==0: idle stays 0, and no word is emitted.
- FILL with i_flush and cnt>0 (or a same-cycle pop): go to HOLD. A byte popped in the flush cycle is included.
- i_flush with cnt==0 and no pop is ignored.
- Lanes not written in a partial word are driven to zero. o_keep is always contiguous from lane 0.
- HOLD:
  - o_valid=1 and no pops occur.
  - o_data and o_keep are held stable until i_ready=1.
  - On the i_ready edge: go to FILL, clear o_valid, o_keep, cnt and idle.
- i_flush is ignored in HOLD.
- Reset (any time, including mid-word):
  - State becomes FILL; cnt, idle, o_valid, o_keep and o_data all become 0.
  - o_fifo_rinc is 0 while i_rst is high.
  - Partially packed data is discarded.

## Timing
- A pop is performed at the rising edge where o_fifo_rinc=1. The FIFO advances at the same edge.
- Full word: o_valid rises in the cycle following the edge that pops the LANES-th word.
- Minimum period is LANES+1 cycles per output word, because of the HOLD cycle.
- Timeout: o_valid rises in the cycle after the IDLE_MAX-th consecutive idle FILL cycle with cnt>0.
- Flush: o_valid rises in the cycle after the edge that samples i_flush=1.
- Handshake: a transfer occurs at any edge with o_valid & i_ready.
- o_valid never drops without a transfer, except on reset.

## Structure
- Shared package fifo_pkg holds:
  - the state typedef (FILL, HOLD)
  - default WIDTH, LANES and IDLE_MAX constants, used by the FIFO top and this block
- Single module; no sub-module.
- Registers: state, cnt ($clog2(LANES) bits), idle ($clog2(IDLE_MAX+1) bits), o_data, o_keep, o_valid.

## Test plan
- Push 0x11, 0x22, 0x33, 0x44 with i_ready=1 → o_data=0x44332211, o_keep=4'hF, o_valid high for exactly 1 cycle; then exactly 4 pops.
- Queue 8 words 0x55..0xCC with i_ready=0 for 10 cycles:
  - o_fifo_rinc=0 throughout HOLD, o_data stable at 0x88776655.
  - After i_ready=1, the next word is 0xCCBBAA99.
- Push 0xA1, 0xB2, then the FIFO goes empty (IDLE_MAX=16) → after 16 idle cycles o_data=0x0000B2A1, o_keep=4'h3.
- Push 0x01, 0x02, 0x03, then pulse i_flush while empty → next cycle o_data=0x00030201, o_keep=4'h7. i_flush with cnt==0 → o_valid stays 0.
- Assert i_rst with cnt=2:
  - o_valid, o_keep and o_data go to 0 immediately (asynchronously).
  - After release, push 0xD0..0xD3 → o_data=0xD3D2D1D0.
- Hold i_fifo_empty=1 for 50 cycles → o_fifo_rinc never asserts and o_valid stays 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: packer state encoding and default geometry.
package fifo_pkg;

   typedef logic [0:0] state_t;

   localparam state_t FILL = 1'b0;
   localparam state_t HOLD = 1'b1;

   localparam int FIFO_WIDTH    = 8;
   localparam int FIFO_LANES    = 4;
   localparam int FIFO_IDLE_MAX = 16;

endpackage

// File: rtl/fifo_rd_packer.sv
// Packs LANES FIFO words into one wide word; o_valid rises one cycle after the last pop, flush or idle timeout.
// Backpressure: word held and popping stopped until i_ready; at best LANES+1 cycles per output word.
module fifo_rd_packer
   import fifo_pkg::*;
#(
   parameter int WIDTH    = FIFO_WIDTH,
   parameter int LANES    = FIFO_LANES,
   parameter int IDLE_MAX = FIFO_IDLE_MAX
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_fifo_empty,
   input  logic [WIDTH-1:0]       i_fifo_data,
   output logic                   o_fifo_rinc,
   output logic [WIDTH*LANES-1:0] o_data,
   output logic [LANES-1:0]       o_keep,
   output logic                   o_valid,
   input  logic                   i_ready,
   input  logic                   i_flush
);

   localparam int CNT_W  = $clog2(LANES);
   localparam int IDLE_W = (IDLE_MAX > 0) ? $clog2(IDLE_MAX + 1) : 1;

   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(LANES - 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_MAX - 1);

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [IDLE_W-1:0] idle;
   logic              pop;
   logic              timeout;

   assign pop         = (state == FILL) & ~i_fifo_empty & ~i_rst;
   assign o_fifo_rinc = pop;

   // Fires on the IDLE_MAX-th consecutive idle cycle, so o_valid follows one cycle later.
   assign timeout = (IDLE_MAX != 0) && (idle == IDLE_LAST);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state   <= FILL;
         cnt     <= '0;
         idle    <= '0;
         o_data  <= '0;
         o_keep  <= '0;
         o_valid <= 1'b0;
      end else if (state == HOLD) begin
         if (i_ready) begin
            state   <= FILL;
            cnt     <= '0;
            idle    <= '0;
            o_data  <= '0;
            o_keep  <= '0;
            o_valid <= 1'b0;
         end
      end else if (pop) begin
         o_data[cnt*WIDTH +: WIDTH] <= i_fifo_data;
         o_keep[cnt]                <= 1'b1;
         idle                       <= '0;
         if ((cnt == CNT_LAST) || i_flush) begin
            state   <= HOLD;
            cnt     <= '0;
            o_valid <= 1'b1;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end else if (cnt != '0) begin
         if (i_flush || timeout) begin
            state   <= HOLD;
            cnt     <= '0;
            idle    <= '0;
            o_valid <= 1'b1;
         end else if (IDLE_MAX != 0) begin
            idle <= idle + IDLE_W'(1);
         end
      end else begin
         idle <= '0;
      end
   end

endmodule
